eth_cmd_decoder: RTL and testbench

- Receive-side counterpart of the readout frame builder.
- Parses command frames arriving on the Ethernet MAC rx AXI-stream (8-bit) in the mac_clk domain.
- Decodes register-write commands and drives the run-control outputs: MAC addresses, thresholds, TDS mode, channel enable and soft reset.
- Lets a host PC configure the sTGC TDS logger over the link instead of through VIO.

---
 rtl/eth_cmd_decoder.sv | 237 +++++++++++++++++++++++
 tb/tb_eth_cmd_decoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_cmd_decoder.sv
// ----------------------------------------------------------------------------
// eth_cmd_decoder
//
// Parses register-write command frames from the Ethernet MAC rx AXI-stream.
// Each accepted frame updates one run-control output, the readout MAC
// addresses, the thresholds, TDS mode, channel enable or the soft-reset pulse.
// A host PC can therefore configure the sTGC TDS logger over the link.
//
// Frame layout (byte index from start of frame):
//   0-5 dst MAC, 6-11 src MAC, 12-13 EtherType, 14 opcode, 15 reg address,
//   16-21 48-bit data (MSB first), 22+ padding.
//
// Optional build macro: ETH_CMD_STATUS_CNT_EN
//   defined   : frame_ok_cnt / frame_drop_cnt count accepted / dropped frames
//   undefined : both counters are absent and the ports read 16'h0000
//
// Ports:
//   clk                     MAC clock
//   reset                   synchronous, active-high
//   rx_axis_fifo_tdata      frame byte
//   rx_axis_fifo_tvalid     byte valid
//   rx_axis_fifo_tready     byte accept (low only during reset)
//   rx_axis_fifo_tlast      last byte of frame
//   d_mac_add / s_mac_add   destination / source MAC used by readout
//   counter_th              readout packet threshold
//   idle_counter_number_th  idle flush threshold
//   tds_mode                0 = pad, 1 = strip
//   enable                  per-channel enable
//   soft_reset              system reset pulse, RST_PULSE_LEN cycles long
//   cmd_valid               one-cycle strobe per committed write
//   cmd_addr                address of the last committed write
//   frame_ok_cnt            accepted-frame count
//   frame_drop_cnt          dropped-frame count
// ----------------------------------------------------------------------------
module eth_cmd_decoder #(
   parameter logic [47:0] LOCAL_MAC      = 48'h00_0A_35_00_00_01,
   parameter logic [15:0] CMD_ETHERTYPE  = 16'h88B5,
   parameter logic [11:0] DEF_COUNTER_TH = 12'd256,
   parameter logic [11:0] DEF_IDLE_TH    = 12'd1024,
   parameter int unsigned RST_PULSE_LEN  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_axis_fifo_tdata,
   input  logic        rx_axis_fifo_tvalid,
   output logic        rx_axis_fifo_tready,
   input  logic        rx_axis_fifo_tlast,
   output logic [47:0] d_mac_add,
   output logic [47:0] s_mac_add,
   output logic [11:0] counter_th,
   output logic [11:0] idle_counter_number_th,
   output logic        tds_mode,
   output logic [3:0]  enable,
   output logic        soft_reset,
   output logic        cmd_valid,
   output logic [7:0]  cmd_addr,
   output logic [15:0] frame_ok_cnt,
   output logic [15:0] frame_drop_cnt
);

   localparam int unsigned CNT_W  = 6;
   localparam int unsigned RST_W  = 8;
   localparam int unsigned STAT_W = 16;

   localparam logic [CNT_W-1:0] CNT_MAX        = CNT_W'(63);
   localparam logic [CNT_W-1:0] IDX_DST_LAST   = CNT_W'(5);
   localparam logic [CNT_W-1:0] IDX_ET_HI      = CNT_W'(12);
   localparam logic [CNT_W-1:0] IDX_ET_LO      = CNT_W'(13);
   localparam logic [CNT_W-1:0] IDX_OPCODE     = CNT_W'(14);
   localparam logic [CNT_W-1:0] IDX_ADDR       = CNT_W'(15);
   localparam logic [CNT_W-1:0] IDX_DATA_FIRST = CNT_W'(16);
   localparam logic [CNT_W-1:0] IDX_DATA_LAST  = CNT_W'(21);

   localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
   localparam logic [7:0]  OPC_WRITE = 8'h01;

   localparam logic [7:0] ADDR_D_MAC    = 8'h01;
   localparam logic [7:0] ADDR_S_MAC    = 8'h02;
   localparam logic [7:0] ADDR_CNT_TH   = 8'h03;
   localparam logic [7:0] ADDR_IDLE_TH  = 8'h04;
   localparam logic [7:0] ADDR_TDS_MODE = 8'h05;
   localparam logic [7:0] ADDR_ENABLE   = 8'h06;
   localparam logic [7:0] ADDR_SOFT_RST = 8'h07;

   typedef enum logic [1:0] {
      RECV   = 2'd0,
      DRAIN  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              beat_c;
   logic              last_beat_c;
   logic              mismatch_c;
   logic              rst_load_c;
   logic [CNT_W-1:0]  idx;
   logic [39:0]       dst_hold;
   logic [7:0]        etype_hi;
   logic [7:0]        addr_hold;
   logic [47:0]       data_hold;
   logic [RST_W-1:0]  rst_cnt;
   logic [RST_W-1:0]  rst_cnt_next_c;

   // Never backpressure outside reset.
   assign rx_axis_fifo_tready = ~reset;
   assign beat_c      = rx_axis_fifo_tvalid & rx_axis_fifo_tready;
   assign last_beat_c = beat_c & rx_axis_fifo_tlast;

   // Header check on the byte that completes each field.
   always_comb begin
      mismatch_c = 1'b0;
      case (idx)
         IDX_DST_LAST: mismatch_c = ({dst_hold, rx_axis_fifo_tdata} != LOCAL_MAC) &&
                                    ({dst_hold, rx_axis_fifo_tdata} != BCAST_MAC);
         IDX_ET_LO:    mismatch_c = ({etype_hi, rx_axis_fifo_tdata} != CMD_ETHERTYPE);
         IDX_OPCODE:   mismatch_c = (rx_axis_fifo_tdata != OPC_WRITE);
         default:      mismatch_c = 1'b0;
      endcase
   end

   // Parser state register.
   always_ff @(posedge clk) begin
      if (reset) state <= RECV;
      else       state <= state_next;
   end

   // Next-state logic; COMMIT lasts one cycle but still parses byte 0 of a
   // back-to-back frame, since the byte counter was cleared on the tlast beat.
   always_comb begin
      state_next = state;
      case (state)
         RECV, COMMIT: begin
            state_next = RECV;
            if (beat_c) begin
               if (rx_axis_fifo_tlast)
                  state_next = (idx >= IDX_DATA_LAST) ? COMMIT : RECV;
               else if (mismatch_c)
                  state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (last_beat_c) state_next = RECV;
         end
         default: state_next = RECV;
      endcase
   end

   // Byte counter and field holding registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx       <= '0;
         dst_hold  <= '0;
         etype_hi  <= '0;
         addr_hold <= '0;
         data_hold <= '0;
      end else if (beat_c) begin
         if (rx_axis_fifo_tlast)  idx <= '0;
         else if (idx != CNT_MAX) idx <= idx + CNT_W'(1);

         if (idx < IDX_DST_LAST) dst_hold  <= {dst_hold[31:0], rx_axis_fifo_tdata};
         if (idx == IDX_ET_HI)   etype_hi  <= rx_axis_fifo_tdata;
         if (idx == IDX_ADDR)    addr_hold <= rx_axis_fifo_tdata;
         if ((idx >= IDX_DATA_FIRST) && (idx <= IDX_DATA_LAST))
            data_hold <= {data_hold[39:0], rx_axis_fifo_tdata};
      end
   end

   // Register writes from the latched fields; a new frame only touches
   // dst_hold during COMMIT, so the pending write is stable.
   always_ff @(posedge clk) begin
      if (reset) begin
         d_mac_add              <= BCAST_MAC;
         s_mac_add              <= LOCAL_MAC;
         counter_th             <= DEF_COUNTER_TH;
         idle_counter_number_th <= DEF_IDLE_TH;
         tds_mode               <= 1'b0;
         enable                 <= 4'hF;
         cmd_valid              <= 1'b0;
         cmd_addr               <= '0;
      end else begin
         cmd_valid <= 1'b0;
         if (state == COMMIT) begin
            cmd_valid <= 1'b1;
            cmd_addr  <= addr_hold;
            case (addr_hold)
               ADDR_D_MAC:    d_mac_add              <= data_hold;
               ADDR_S_MAC:    s_mac_add              <= data_hold;
               ADDR_CNT_TH:   counter_th             <= data_hold[11:0];
               ADDR_IDLE_TH:  idle_counter_number_th <= data_hold[11:0];
               ADDR_TDS_MODE: tds_mode               <= data_hold[0];
               ADDR_ENABLE:   enable                 <= data_hold[3:0];
               default:       ;
            endcase
         end
      end
   end

   // Soft-reset pulse: counter holds the remaining high cycles, a new write
   // reloads it so the pulse runs RST_PULSE_LEN cycles from the last commit.
   assign rst_load_c = (state == COMMIT) && (addr_hold == ADDR_SOFT_RST);

   always_comb begin
      rst_cnt_next_c = rst_cnt;
      if (rst_load_c)          rst_cnt_next_c = RST_W'(RST_PULSE_LEN);
      else if (rst_cnt != '0)  rst_cnt_next_c = rst_cnt - RST_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rst_cnt    <= '0;
         soft_reset <= 1'b0;
      end else begin
         rst_cnt    <= rst_cnt_next_c;
         soft_reset <= (rst_cnt_next_c != '0);
      end
   end

`ifdef ETH_CMD_STATUS_CNT_EN
   // Status counters; a tlast beat that does not lead to COMMIT is a drop.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_ok_cnt   <= '0;
         frame_drop_cnt <= '0;
      end else begin
         if (state == COMMIT)
            frame_ok_cnt <= frame_ok_cnt + STAT_W'(1);
         if (last_beat_c && (state_next != COMMIT))
            frame_drop_cnt <= frame_drop_cnt + STAT_W'(1);
      end
   end
`else
   assign frame_ok_cnt   = STAT_W'(0);
   assign frame_drop_cnt = STAT_W'(0);
`endif

endmodule

// File: tb/tb_eth_cmd_decoder.sv
`timescale 1ns/1ps
module tb_eth_cmd_decoder;

   localparam logic [47:0] LOCAL_MAC = 48'h00_0A_35_00_00_01;
   localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
   localparam logic [15:0] ETYPE     = 16'h88B5;
   localparam int          PULSE     = 30;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  tdata = '0;
   logic        tvalid = 1'b0;
   logic        tready;
   logic        tlast = 1'b0;
   logic [47:0] d_mac_add, s_mac_add;
   logic [11:0] counter_th, idle_th;
   logic        tds_mode, soft_reset, cmd_valid;
   logic [3:0]  enable;
   logic [7:0]  cmd_addr;
   logic [15:0] ok_cnt, drop_cnt;

   always #4 clk = ~clk;

   eth_cmd_decoder #(.RST_PULSE_LEN(PULSE)) dut (
      .clk(clk), .reset(reset),
      .rx_axis_fifo_tdata(tdata), .rx_axis_fifo_tvalid(tvalid),
      .rx_axis_fifo_tready(tready), .rx_axis_fifo_tlast(tlast),
      .d_mac_add(d_mac_add), .s_mac_add(s_mac_add),
      .counter_th(counter_th), .idle_counter_number_th(idle_th),
      .tds_mode(tds_mode), .enable(enable), .soft_reset(soft_reset),
      .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
      .frame_ok_cnt(ok_cnt), .frame_drop_cnt(drop_cnt)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [47:0] dmac;
      logic [47:0] smac;
      logic [11:0] cth;
      logic [11:0] ith;
      logic        tds;
      logic [3:0]  en;
      logic [15:0] ok;
      logic [15:0] drop;
   } snap_t;

   snap_t      m;
   snap_t      exp_q[$];
   logic [7:0] fr[$];
   int         asserts = 0;
   int         fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_cnt(input logic [15:0] v);
`ifdef ETH_CMD_STATUS_CNT_EN
      return v;
`else
      return v & 16'h0000;
`endif
   endfunction

   task automatic model_reset();
      m.addr = 8'h00;  m.dmac = BCAST;   m.smac = LOCAL_MAC;
      m.cth  = 12'd256; m.ith = 12'd1024; m.tds = 1'b0; m.en = 4'hF;
      m.ok   = 16'h0;  m.drop = 16'h0;
   endtask

   // Reference: a frame is accepted iff it is at least 22 bytes long and its
   // dst/EtherType/opcode fields are right; accepted frames apply their write.
   task automatic model_frame(input int start);
      logic [7:0]  b[$];
      logic [47:0] dst, data;
      bit          ok;
      for (int i = start; i < fr.size(); i++) b.push_back(fr[i]);
      ok = 1'b0;
      if (b.size() >= 22) begin
         dst  = {b[0], b[1], b[2], b[3], b[4], b[5]};
         data = {b[16], b[17], b[18], b[19], b[20], b[21]};
         ok = ((dst == LOCAL_MAC) || (dst == BCAST)) &&
              ({b[12], b[13]} == ETYPE) && (b[14] == 8'h01);
         if (ok) begin
            m.addr = b[15];
            case (b[15])
               8'h01: m.dmac = data;
               8'h02: m.smac = data;
               8'h03: m.cth  = data[11:0];
               8'h04: m.ith  = data[11:0];
               8'h05: m.tds  = data[0];
               8'h06: m.en   = data[3:0];
               default: ;
            endcase
            m.ok = m.ok + 16'd1;
            exp_q.push_back(m);
         end
      end
      if (!ok) m.drop = m.drop + 16'd1;
   endtask

   task automatic build_frame(input logic [47:0] dst, input logic [15:0] et,
                              input logic [7:0] opc, input logic [7:0] addr,
                              input logic [47:0] data, input int len);
      logic [7:0]  b;
      logic [47:0] src;
      src = {16'h000A, $urandom};
      fr.delete();
      for (int i = 0; i < len; i++) begin
         if (i < 6)        b = dst[8*(5-i) +: 8];
         else if (i < 12)  b = src[8*(11-i) +: 8];
         else if (i == 12) b = et[15:8];
         else if (i == 13) b = et[7:0];
         else if (i == 14) b = opc;
         else if (i == 15) b = addr;
         else if (i < 22)  b = data[8*(21-i) +: 8];
         else              b = 8'($urandom);
         fr.push_back(b);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".cmd_addr"}, 64'(cmd_addr),   64'(m.addr));
      check({tag, ".d_mac"},    64'(d_mac_add),  64'(m.dmac));
      check({tag, ".s_mac"},    64'(s_mac_add),  64'(m.smac));
      check({tag, ".cnt_th"},   64'(counter_th), 64'(m.cth));
      check({tag, ".idle_th"},  64'(idle_th),    64'(m.ith));
      check({tag, ".tds"},      64'(tds_mode),   64'(m.tds));
      check({tag, ".enable"},   64'(enable),     64'(m.en));
      check({tag, ".ok_cnt"},   64'(ok_cnt),     64'(exp_cnt(m.ok)));
      check({tag, ".drop_cnt"}, 64'(drop_cnt),   64'(exp_cnt(m.drop)));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         tvalid = 1'b0;
         tlast  = 1'b0;
      end
   endtask

   // Drives fr; optional one-cycle reset before byte reset_at.
   task automatic send_frame(input int reset_at, input bit bubbles);
      int guard;
      if (reset_at < 0) model_frame(0);
      for (int i = 0; i < fr.size(); i++) begin
         if (i == reset_at) begin
            @(negedge clk);
            tvalid = 1'b0; tlast = 1'b0; reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            model_reset();
            check_state("mid_reset");
            check("mid_reset.soft_reset", 64'(soft_reset), 64'(0));
            model_frame(reset_at);
         end
         @(negedge clk);
         while (bubbles && ($urandom_range(0, 3) == 0)) begin
            tvalid = 1'b0;
            @(negedge clk);
         end
         tvalid = 1'b1;
         tdata  = fr[i];
         tlast  = (i == fr.size() - 1);
         guard  = 0;
         do begin
            @(posedge clk);
            guard++;
         end while (!tready && guard < 10);
         if (!tready) check("handshake_timeout", 64'(tready), 64'(1));
      end
   endtask

   // Monitor: every cmd_valid pops one expected commit; soft_reset is tracked
   // as "high for PULSE cycles starting at the latest address-07 commit".
   initial begin
      snap_t e;
      int    sr_left;
      sr_left = 0;
      forever begin
         @(negedge clk);
         if (cmd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_cmd_valid", 64'(cmd_valid), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("mon.cmd_addr", 64'(cmd_addr),   64'(e.addr));
               check("mon.d_mac",    64'(d_mac_add),  64'(e.dmac));
               check("mon.s_mac",    64'(s_mac_add),  64'(e.smac));
               check("mon.cnt_th",   64'(counter_th), 64'(e.cth));
               check("mon.idle_th",  64'(idle_th),    64'(e.ith));
               check("mon.tds",      64'(tds_mode),   64'(e.tds));
               check("mon.enable",   64'(enable),     64'(e.en));
               check("mon.ok_cnt",   64'(ok_cnt),     64'(exp_cnt(e.ok)));
               check("mon.drop_cnt", 64'(drop_cnt),   64'(exp_cnt(e.drop)));
               if (e.addr == 8'h07) sr_left = PULSE;
            end
         end
         check("mon.soft_reset", 64'(soft_reset), 64'(sr_left > 0));
         if (sr_left > 0) sr_left--;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] dst, data;
      logic [15:0] et;
      logic [7:0]  opc;
      int          len, r;

      model_reset();
      repeat (3) @(negedge clk);
      check("reset.tready", 64'(tready), 64'(0));
      check("reset.cmd_valid", 64'(cmd_valid), 64'(0));
      check_state("reset");
      reset = 1'b0;
      @(negedge clk);
      check("run.tready", 64'(tready), 64'(1));

      // Write counter_th through LOCAL_MAC, 60-byte frame.
      build_frame(LOCAL_MAC, ETYPE, 8'h01, 8'h03, 48'h0000_0000_0123, 60);
      send_frame(-1, 1'b0);
      idle(5);
      check_state("cnt_th_write");

      // Destination mismatch on byte 5.
      build_frame(48'h000A35000002, ETYPE, 8'h01, 8'h03, 48'h0000_0000_0456, 60);
      send_frame(-1, 1'b0);
      idle(5);
      check_state("dst_mismatch");

      // Broadcast soft reset, second one committed while the pulse runs.
      build_frame(BCAST, ETYPE, 8'h01, 8'h07, 48'h0, 22);
      send_frame(-1, 1'b0);
      build_frame(BCAST, ETYPE, 8'h01, 8'h07, 48'h0, 22);
      send_frame(-1, 1'b0);
      idle(PULSE + 10);
      check_state("soft_reset");

      // Runt (tlast on byte 18) then enable write, back-to-back.
      build_frame(LOCAL_MAC, ETYPE, 8'h01, 8'h06, 48'h5, 19);
      send_frame(-1, 1'b0);
      build_frame(LOCAL_MAC, ETYPE, 8'h01, 8'h06, 48'h5, 22);
      send_frame(-1, 1'b0);
      idle(5);
      check_state("runt_then_enable");

      // Two valid frames with tvalid held high across the boundary.
      build_frame(LOCAL_MAC, ETYPE, 8'h01, 8'h01, 48'h1234_5678_9ABC, 22);
      send_frame(-1, 1'b0);
      build_frame(LOCAL_MAC, ETYPE, 8'h01, 8'h05, 48'h1, 22);
      send_frame(-1, 1'b0);
      idle(5);
      check_state("back_to_back");

      // Reset at byte 10 of a valid frame, then a normal frame.
      idle(10);
      build_frame(LOCAL_MAC, ETYPE, 8'h01, 8'h04, 48'h0ABC, 60);
      send_frame(10, 1'b0);
      idle(5);
      check_state("after_mid_reset");
      build_frame(LOCAL_MAC, ETYPE, 8'h01, 8'h04, 48'h0ABC, 30);
      send_frame(-1, 1'b0);
      idle(5);
      check_state("post_reset_frame");

      // Randomized traffic.
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 9);
         if (r < 5)       dst = LOCAL_MAC;
         else if (r < 7) dst = BCAST;
         else if (r == 7) dst = LOCAL_MAC ^ (48'h1 << (8 * $urandom_range(0, 5)));
         else             dst = {$urandom, $urandom};
         et   = ($urandom_range(0, 9) == 0) ? 16'($urandom) : ETYPE;
         opc  = ($urandom_range(0, 9) == 0) ? 8'($urandom)  : 8'h01;
         data = {16'($urandom), $urandom};
         len  = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 21) : $urandom_range(22, 70);
         build_frame(dst, et, opc, 8'($urandom_range(0, 9)), data, len);
         send_frame(-1, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 4));
      end
      idle(PULSE + 10);
      check_state("random_end");
      check("queue_empty", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
